bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning BRAM address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning BRAM data width in bits.
REQ-003 The block SHALL have parameter NB_REQ, default 4, meaning number of requesters (legal range 2..8).
REQ-004 The block SHALL have port aclk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port aresetn, input, 1, meaning reset, asynchronous assertion, active-low.
REQ-006 The block SHALL have port req_valid, input, NB_REQ, meaning per-requester request valid.
REQ-007 The block SHALL have port req_ready, output, NB_REQ, meaning per-requester request accepted this cycle.
REQ-008 The block SHALL have port req_wr, input, NB_REQ, meaning per-requester access type (1 = write, 0 = read).
REQ-009 The block SHALL have port req_addr, input, NB_REQ*ADDR_WIDTH, meaning per-requester address; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 The block SHALL have port req_wdata, input, NB_REQ*DATA_WIDTH, meaning per-requester write data, sliced the same way.
REQ-011 The block SHALL have port rsp_valid, output, NB_REQ, meaning one-hot read-data-valid per requester.
REQ-012 The block SHALL have port rsp_data, output, DATA_WIDTH, meaning read data shared by all requesters.
REQ-013 The block SHALL have ports wren (output, 1), wraddr (output, ADDR_WIDTH) and wrdata (output, DATA_WIDTH), meaning the BRAM write port.
REQ-014 The block SHALL have ports rden (output, 1), rdaddr (output, ADDR_WIDTH) and rddata (input, DATA_WIDTH), meaning the BRAM read port; the BRAM is clocked by aclk with 1-cycle registered read.

Function
REQ-015 Handshake: a request SHALL transfer when req_valid[i] and req_ready[i] are both 1; req_ready SHALL be combinational from current valids and arbiter state; a requester holds valid, wr, addr and wdata stable until accepted.
REQ-016 Write and read SHALL be arbitrated independently; per cycle, at most one write grant and at most one read grant.
REQ-017 Each arbiter SHALL be round-robin: priority starts at requester (last_grant+1) mod NB_REQ; its pointer updates only on a grant; reset pointer value NB_REQ-1, so requester 0 has first priority.
REQ-018 A write grant to requester i SHALL drive wren=1, wraddr=addr_i and wrdata=wdata_i combinationally in the same cycle.
REQ-019 A read grant to requester j SHALL drive rden=1 and rdaddr=addr_j combinationally in the same cycle.
REQ-020 Read latency: rsp_valid[j] SHALL be 1 exactly one cycle after the read grant, with rsp_data=rddata in that cycle; back-to-back reads SHALL give back-to-back responses; there is no response backpressure.
REQ-021 Hazard: if the winning write and the winning read in one cycle have equal addresses, the read SHALL NOT be granted (rden=0, ready=0); the read arbiter pointer SHALL be unchanged; the read is granted next cycle and returns the new data.
REQ-022 When no request is granted, wren/rden SHALL be 0; wraddr, wrdata and rdaddr SHALL be 0.
REQ-023 A requester with valid=0 SHALL never be granted.
REQ-024 Starvation bound: a continuously valid requester SHALL be granted within NB_REQ cycles, or NB_REQ+1 cycles for reads delayed by REQ-021.

Reset
REQ-025 While aresetn=0: req_ready, rsp_valid, wren and rden SHALL be 0; rsp_data, wraddr, wrdata and rdaddr SHALL be 0; both pointers SHALL be NB_REQ-1.
REQ-026 If reset asserts with a read in flight, the pending rsp_valid SHALL be discarded and SHALL NOT appear after release.
REQ-027 The first grant SHALL be possible in the first rising edge after aresetn deasserts.

Verification
REQ-028 All 4 requesters write continuously -> grants in order 0,1,2,3,0; each ready high exactly 1 cycle in 4.
REQ-029 Req0 writes 0xDEADBEEF to addr 0x10 and req1 reads addr 0x10 in the same cycle -> the read is deferred 1 cycle; req1 rsp_valid arrives 2 cycles after the request, with data 0xDEADBEEF.
REQ-030 Req2 write addr 0x05 and req3 read addr 0x06 in the same cycle -> both granted in that cycle; rsp_valid[3] one cycle later.
REQ-031 Req1 reads addr 0x20, then 0x21 on consecutive cycles -> rsp_valid[1]=1 for 2 consecutive cycles with the matching data.
REQ-032 Reset asserted one cycle after a read grant -> no rsp_valid after release; first subsequent grant goes to the lowest valid index.
REQ-033 Random valid/wr/addr traffic for 10k cycles -> scoreboard memory model matches every response, and no requester waits beyond the REQ-024 bound.

Source files
------------

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - independent round-robin write/read arbiters sharing one simple dual-port BRAM
// Read grants are withheld when they collide with the same-cycle write address.
module bram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NB_REQ     = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NB_REQ-1:0]            req_valid,
    output logic [NB_REQ-1:0]            req_ready,
    input  logic [NB_REQ-1:0]            req_wr,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NB_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NB_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         wren,
    output logic [ADDR_WIDTH-1:0]        wraddr,
    output logic [DATA_WIDTH-1:0]        wrdata,
    output logic                         rden,
    output logic [ADDR_WIDTH-1:0]        rdaddr,
    input  logic [DATA_WIDTH-1:0]        rddata
);
    localparam int IDX_W = $clog2(NB_REQ);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NB_REQ - 1);

    logic [IDX_W-1:0]      r_wr_ptr;
    logic [IDX_W-1:0]      r_rd_ptr;
    logic [NB_REQ-1:0]     r_rsp_valid;

    logic [NB_REQ-1:0]     w_wr_cand;
    logic [NB_REQ-1:0]     w_rd_cand;
    logic                  w_wr_found;
    logic                  w_rd_found;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_hazard;
    logic                  w_rd_gnt;
    logic [NB_REQ-1:0]     w_rd_onehot;

    // Walk from lowest to highest priority so the highest-priority candidate is written last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NB_REQ-1:0] cand,
                                               input logic [IDX_W-1:0]  last);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = NB_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NB_REQ;
            if (cand[IDX_W'(idx)]) begin
                res = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    assign w_wr_cand = req_valid &  req_wr & {NB_REQ{aresetn}};
    assign w_rd_cand = req_valid & ~req_wr & {NB_REQ{aresetn}};

    assign {w_wr_found, w_wr_idx} = rr_pick(w_wr_cand, r_wr_ptr);
    assign {w_rd_found, w_rd_idx} = rr_pick(w_rd_cand, r_rd_ptr);

    assign w_wr_addr = req_addr[w_wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_rd_addr = req_addr[w_rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wr_data = req_wdata[w_wr_idx*DATA_WIDTH +: DATA_WIDTH];

    // Deferring the colliding read one cycle lets it observe the freshly written word.
    assign w_hazard = w_wr_found && w_rd_found && (w_wr_addr == w_rd_addr);
    assign w_rd_gnt = w_rd_found && !w_hazard;

    always_comb begin
        w_rd_onehot = '0;
        req_ready   = '0;
        if (w_rd_gnt) begin
            w_rd_onehot[w_rd_idx] = 1'b1;
            req_ready[w_rd_idx]   = 1'b1;
        end
        if (w_wr_found) begin
            req_ready[w_wr_idx] = 1'b1;
        end
    end

    assign wren   = w_wr_found;
    assign wraddr = w_wr_found ? w_wr_addr : '0;
    assign wrdata = w_wr_found ? w_wr_data : '0;
    assign rden   = w_rd_gnt;
    assign rdaddr = w_rd_gnt ? w_rd_addr : '0;

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = (|r_rsp_valid) ? rddata : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr    <= PTR_RST;
            r_rd_ptr    <= PTR_RST;
            r_rsp_valid <= '0;
        end else begin
            if (w_wr_found) begin
                r_wr_ptr <= w_wr_idx;
            end
            if (w_rd_gnt) begin
                r_rd_ptr <= w_rd_idx;
            end
            r_rsp_valid <= w_rd_onehot;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter: vector table, corner sequences, random scoreboard
module tb_bram_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int N  = 4;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic [N-1:0]  req_valid, req_ready, req_wr, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_data, wrdata, rddata;
    logic          wren, rden;
    logic [AW-1:0] wraddr, rdaddr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] bram [256];

    always #5 aclk = ~aclk;

    bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_REQ(N)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .rden(rden), .rdaddr(rdaddr), .rddata(rddata)
    );

    // BRAM with one-cycle registered read
    always @(posedge aclk) begin
        if (rden) rddata <= bram[rdaddr];
        if (wren) bram[wraddr] = wrdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_wr[i]             = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        aresetn = 1'b0;
        clear_reqs();
        next_cycle();
        aresetn = 1'b1;
    endtask

    function automatic int pick(input logic [N-1:0] c, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0]    valid;
        logic [N-1:0]    wr;
        logic [N*AW-1:0] addr;
        logic [N-1:0]    exp_ready;
        logic            exp_wren;
        logic [AW-1:0]   exp_wraddr;
        logic            exp_rden;
        logic [AW-1:0]   exp_rdaddr;
        logic [N-1:0]    exp_rsp;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N*AW-1:0] a,
                                input logic [N-1:0] er, input logic ewe, input logic [AW-1:0] ewa,
                                input logic ere, input logic [AW-1:0] era, input logic [N-1:0] ers);
        vec_t t;
        t.valid = v; t.wr = w; t.addr = a;
        t.exp_ready = er; t.exp_wren = ewe; t.exp_wraddr = ewa;
        t.exp_rden = ere; t.exp_rdaddr = era; t.exp_rsp = ers;
        return t;
    endfunction

    vec_t vecs[8];

    // random-phase state
    logic          act   [N];
    logic          r_wr  [N];
    logic [AW-1:0] r_addr[N];
    logic [DW-1:0] r_wd  [N];
    int            waited[N];
    int            stall [N];
    logic [DW-1:0] shadow[256];

    initial begin
        logic [N*AW-1:0] a4;
        int            m_wr_last, m_rd_last, wi, ri, bound;
        logic          haz;
        logic [N-1:0]  wc, rc, exp_ready, exp_rsp_valid, granted;
        logic [DW-1:0] exp_rsp_data;

        for (int i = 0; i < 256; i++) bram[i] = '0;
        rddata = '0;
        a4 = {8'h13, 8'h12, 8'h11, 8'h10};
        vecs[0] = mk(4'hF, 4'hF, a4, 4'b0001, 1'b1, 8'h10, 1'b0, 8'h00, 4'b0000);
        vecs[1] = mk(4'hF, 4'hF, a4, 4'b0010, 1'b1, 8'h11, 1'b0, 8'h00, 4'b0000);
        vecs[2] = mk(4'hF, 4'hF, a4, 4'b0100, 1'b1, 8'h12, 1'b0, 8'h00, 4'b0000);
        vecs[3] = mk(4'hF, 4'hF, a4, 4'b1000, 1'b1, 8'h13, 1'b0, 8'h00, 4'b0000);
        vecs[4] = mk(4'hF, 4'hF, a4, 4'b0001, 1'b1, 8'h10, 1'b0, 8'h00, 4'b0000);
        vecs[5] = mk(4'b1100, 4'b0100, {8'h06, 8'h05, 16'h0000}, 4'b1100, 1'b1, 8'h05, 1'b1, 8'h06, 4'b0000);
        vecs[6] = mk(4'h0, 4'h0, '0, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 4'b1000);
        vecs[7] = mk(4'h0, 4'h0, '0, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0000);

        // reset holds everything quiet even with requests pending
        clear_reqs();
        set_req(0, 1'b1, 1'b1, 8'h10, 32'h1111_1111);
        set_req(1, 1'b1, 1'b0, 8'h20, 32'h0);
        @(negedge aclk);
        @(negedge aclk);
        chk("rst_ready", req_ready, 0);
        chk("rst_wren", wren, 0);
        chk("rst_rden", rden, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_wraddr", wraddr, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_rdaddr", rdaddr, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        req_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

        // vector table: rotating writes, then parallel write/read at different addresses
        for (int v = 0; v < 8; v++) begin
            req_valid = vecs[v].valid;
            req_wr    = vecs[v].wr;
            req_addr  = vecs[v].addr;
            @(negedge aclk);
            chk($sformatf("vec%0d_ready", v), req_ready, vecs[v].exp_ready);
            chk($sformatf("vec%0d_wren", v), wren, vecs[v].exp_wren);
            chk($sformatf("vec%0d_wraddr", v), wraddr, vecs[v].exp_wraddr);
            chk($sformatf("vec%0d_rden", v), rden, vecs[v].exp_rden);
            chk($sformatf("vec%0d_rdaddr", v), rdaddr, vecs[v].exp_rdaddr);
            chk($sformatf("vec%0d_rsp_valid", v), rsp_valid, vecs[v].exp_rsp);
            next_cycle();
        end

        // same-address write/read: read deferred one cycle and returns the new word
        do_reset();
        set_req(0, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        set_req(1, 1'b1, 1'b0, 8'h10, 32'h0);
        @(negedge aclk);
        chk("haz_ready0", req_ready, 4'b0001);
        chk("haz_wraddr", wraddr, 8'h10);
        chk("haz_wrdata", wrdata, 32'hDEAD_BEEF);
        chk("haz_rden0", rden, 0);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge aclk);
        chk("haz_ready1", req_ready, 4'b0010);
        chk("haz_rden1", rden, 1);
        chk("haz_rdaddr1", rdaddr, 8'h10);
        chk("haz_rsp_early", rsp_valid, 0);
        next_cycle();
        clear_reqs();
        @(negedge aclk);
        chk("haz_rsp_valid", rsp_valid, 4'b0010);
        chk("haz_rsp_data", rsp_data, 32'hDEAD_BEEF);

        // back-to-back reads give back-to-back responses
        next_cycle();
        set_req(0, 1'b1, 1'b1, 8'h20, 32'hA0A0_0020);
        next_cycle();
        set_req(0, 1'b1, 1'b1, 8'h21, 32'hA1A1_0021);
        next_cycle();
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 8'h20, 32'h0);
        @(negedge aclk);
        chk("b2b_ready0", req_ready, 4'b0010);
        chk("b2b_rdaddr0", rdaddr, 8'h20);
        next_cycle();
        set_req(1, 1'b1, 1'b0, 8'h21, 32'h0);
        @(negedge aclk);
        chk("b2b_ready1", req_ready, 4'b0010);
        chk("b2b_rsp_valid0", rsp_valid, 4'b0010);
        chk("b2b_rsp_data0", rsp_data, 32'hA0A0_0020);
        next_cycle();
        clear_reqs();
        @(negedge aclk);
        chk("b2b_rsp_valid1", rsp_valid, 4'b0010);
        chk("b2b_rsp_data1", rsp_data, 32'hA1A1_0021);
        next_cycle();
        @(negedge aclk);
        chk("b2b_rsp_idle", rsp_valid, 0);

        // reset with a read in flight drops the response
        next_cycle();
        set_req(2, 1'b1, 1'b0, 8'h20, 32'h0);
        @(negedge aclk);
        chk("rif_ready", req_ready, 4'b0100);
        next_cycle();
        aresetn = 1'b0;
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 8'h21, 32'h0);
        set_req(3, 1'b1, 1'b0, 8'h20, 32'h0);
        @(negedge aclk);
        chk("rif_rsp_in_reset", rsp_valid, 0);
        chk("rif_ready_in_reset", req_ready, 0);
        chk("rif_rden_in_reset", rden, 0);
        next_cycle();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rif_rsp_after", rsp_valid, 0);
        chk("rif_first_grant", req_ready, 4'b0010);
        chk("rif_first_addr", rdaddr, 8'h21);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge aclk);
        chk("rif_rsp1", rsp_valid, 4'b0010);
        chk("rif_data1", rsp_data, 32'hA1A1_0021);
        chk("rif_ready3", req_ready, 4'b1000);
        next_cycle();
        clear_reqs();
        @(negedge aclk);
        chk("rif_rsp3", rsp_valid, 4'b1000);
        chk("rif_data3", rsp_data, 32'hA0A0_0020);

        // randomized traffic against a scoreboard memory model
        do_reset();
        for (int i = 0; i < 256; i++) shadow[i] = bram[i];
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; waited[i] = 0; stall[i] = 0;
        end
        m_wr_last = N - 1;
        m_rd_last = N - 1;
        exp_rsp_valid = '0;
        exp_rsp_data  = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!act[i] && $urandom_range(0, 1) == 1) begin
                    act[i]    = 1'b1;
                    r_wr[i]   = 1'($urandom_range(0, 1));
                    r_addr[i] = AW'($urandom_range(0, 15));
                    r_wd[i]   = $urandom;
                    waited[i] = 0;
                    stall[i]  = 0;
                end
                if (act[i]) set_req(i, 1'b1, r_wr[i], r_addr[i], r_wd[i]);
                else        set_req(i, 1'b0, 1'b0, '0, '0);
            end
            @(negedge aclk);
            wc = '0;
            rc = '0;
            for (int i = 0; i < N; i++) begin
                wc[i] = act[i] &&  r_wr[i];
                rc[i] = act[i] && !r_wr[i];
            end
            wi  = pick(wc, m_wr_last);
            ri  = pick(rc, m_rd_last);
            haz = (wi >= 0) && (ri >= 0) && (r_addr[wi] == r_addr[ri]);
            if (haz) ri = -1;
            exp_ready = '0;
            if (wi >= 0) exp_ready[wi] = 1'b1;
            if (ri >= 0) exp_ready[ri] = 1'b1;
            chk("rnd_ready", req_ready, exp_ready);
            chk("rnd_wren", wren, wi >= 0);
            chk("rnd_wraddr", wraddr, (wi >= 0) ? r_addr[wi] : '0);
            chk("rnd_wrdata", wrdata, (wi >= 0) ? r_wd[wi] : '0);
            chk("rnd_rden", rden, ri >= 0);
            chk("rnd_rdaddr", rdaddr, (ri >= 0) ? r_addr[ri] : '0);
            chk("rnd_rsp_valid", rsp_valid, exp_rsp_valid);
            if (exp_rsp_valid != 0) chk("rnd_rsp_data", rsp_data, exp_rsp_data);
            exp_rsp_valid = '0;
            if (ri >= 0) begin
                exp_rsp_valid[ri] = 1'b1;
                exp_rsp_data      = shadow[r_addr[ri]];
                m_rd_last         = ri;
            end
            if (wi >= 0) begin
                shadow[r_addr[wi]] = r_wd[wi];
                m_wr_last          = wi;
            end
            granted = exp_ready;
            for (int i = 0; i < N; i++) begin
                if (act[i]) begin
                    if (granted[i]) begin
                        bound = N - 1 + stall[i];
                        chk($sformatf("rnd_starve_req%0d", i), waited[i] <= bound, 1);
                        act[i] = 1'b0;
                    end else begin
                        waited[i]++;
                        if (haz && !r_wr[i]) stall[i]++;
                    end
                end
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
